multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle RV32I datapath. Consumes Op/F3/F7 from the IR and the ALU flags Zero/SignBit.
//  Drives every datapath enable and mux select, one state per cycle.
//  Supports: R add/sub/and/or/xor/slt; I addi/andi/ori/xori/slti; lw, sw, beq/bne/blt/bge, jal, jalr, lui.
// PARAMETERS
//  STATE_W  4  width of state register and State debug port
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  Op         in   7  Inst[6:0]
//  F3         in   3  Inst[14:12]
//  F7         in   7  Inst[31:25]
//  Zero       in   1  ALU result == 0 (combinational)
//  SignBit    in   1  ALU result[31] (combinational)
//  PcEn       out  1  PC load from ResultOut
//  AdrSrc     out  1  mem addr: 0=PC, 1=ResultOut
//  MemWrite   out  1  memory write (data = rs2)
//  IrWrite    out  1  IR and OldPC load
//  RegWrite   out  1  register file write to rd
//  Immsrc     out  3  000=I 001=S 010=B 011=J 100=U
//  AluSrcA    out  2  00=PC 01=OldPC 10=RegA 11=0
//  AluSrcB    out  2  00=RegB 01=Imm 10=4 11=0
//  AluOp      out  3  000=add 001=sub 010=and 011=or 100=xor
//  ResultSrc  out  2  00=AluOutReg 01=MDR 10=AluOut 11=SignBitReg
//  RDS        out  2  reg data: 00=Result 01=Imm 10=AluOutReg
//  Illegal    out  1  sticky: unsupported instruction decoded
//  State      out  STATE_W  current state (debug)
// BEHAVIOUR
//  Outputs are Moore functions of state, with two exceptions:
//   - PcEn in BRANCH depends on Zero/SignBit.
//   - AluOp in EXEC_R/EXEC_I depends on F3/F7.
//  Any output not listed for a state is 0.
//  Reset: state<=FETCH, Illegal<=0. While rst=1, PcEn/MemWrite/IrWrite/RegWrite are forced 0.
//  Reset mid-instruction aborts the instruction; fetch restarts on the first clk after rst falls.
//  FETCH:     AdrSrc=0 IrWrite=1 A=00 B=10 add ResultSrc=10 PcEn=1 -> DECODE
//  DECODE:    A=01 B=01 add, Immsrc by Op (B for branch, J for jal). AluOutReg <= OldPC+imm (target).
//             Next: R(0110011)->EXEC_R, I-alu(0010011)->EXEC_I, lw(0000011)/sw(0100011)->MEM_ADR,
//             branch(1100011)->BRANCH, jal(1101111)->JAL, jalr(1100111)->JALR, lui(0110111)->LUI, else ILLEGAL
//  EXEC_R:    A=10 B=00; AluOp from {F7[5],F3}:
//             add=0/000, sub=1/000, and=0/111, or=0/110, xor=0/100, slt=0/010 (uses sub) -> ALU_WB
//  EXEC_I:    A=10 B=01 Immsrc=I; AluOp from F3, slti uses sub -> ALU_WB
//  ALU_WB:    RegWrite=1 RDS=00; ResultSrc=11 if slt/slti else 00 -> FETCH
//  MEM_ADR:   A=10 B=01 add; Immsrc=I (lw) or S (sw) -> MEM_READ (lw) / MEM_WRITE (sw)
//  MEM_READ:  AdrSrc=1 ResultSrc=00 -> MEM_WB
//  MEM_WB:    ResultSrc=01 RDS=00 RegWrite=1 -> FETCH
//  MEM_WRITE: AdrSrc=1 ResultSrc=00 MemWrite=1 -> FETCH
//  BRANCH:    A=10 B=00 sub ResultSrc=00; PcEn = cond -> FETCH
//             cond: beq(F3=000)=Zero, bne(001)=!Zero, blt(100)=SignBit, bge(101)=!SignBit
//             blt/bge ignore signed overflow (documented limitation); other F3 -> ILLEGAL
//  JAL:       ResultSrc=00 PcEn=1; A=01 B=10 add (OldPC+4) -> LINK_WB
//  JALR:      A=10 B=01 Immsrc=I add -> JALR_PC
//  JALR_PC:   ResultSrc=00 PcEn=1; A=01 B=10 add -> LINK_WB
//  LINK_WB:   RDS=10 RegWrite=1 -> FETCH
//  LUI:       Immsrc=U RDS=01 RegWrite=1 -> FETCH
//  ILLEGAL:   Illegal=1, all enables 0; stays until rst
//  Unsupported F3/F7 in EXEC_R/EXEC_I is decoded in DECODE: next state is ILLEGAL.
//  Cycle counts: R/I/lui 4 (lui 3), lw 5, sw 4, branch 3, jal/jalr 4/5.
// TESTING
//  1. rst pulse mid-MEM_WRITE -> MemWrite drops with rst; state FETCH; Illegal=0.
//  2. add x3,x1,x2 (x1=5, x2=7) -> FETCH,DECODE,EXEC_R,ALU_WB; x3=12; one RegWrite pulse.
//  3. slt x4,x1,x2 (x1=-1, x2=3) -> x4=1; (x1=3, x2=-1) -> x4=0.
//  4. lw x5,8(x0) with mem[8]=0xDEADBEEF -> x5=0xDEADBEEF after 5 cycles; sw writes rs2 at addr 8.
//  5. beq taken/not-taken at PC=0x10, imm=+16 -> PC=0x20 / 0x14; bne/blt/bge mirror these cases.
//  6. jal x1,+32 at PC=0x40 -> PC=0x60, x1=0x44. jalr x1,4(x2) with x2=0x100 -> PC=0x104, x1=old PC+4.
//     Op=0x7F -> Illegal=1 sticky, no further writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath. Outputs are Moore functions of state,
// except branch PcEn (uses ALU flags) and the ALU op in the execute states (uses F3/F7).
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         Op,
    input  logic [2:0]         F3,
    input  logic [6:0]         F7,
    input  logic               Zero,
    input  logic               SignBit,
    output logic               PcEn,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IrWrite,
    output logic               RegWrite,
    output logic [2:0]         Immsrc,
    output logic [1:0]         AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [2:0]         AluOp,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         RDS,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_FETCH     = state_t'(0);
    localparam state_t S_DECODE    = state_t'(1);
    localparam state_t S_EXEC_R    = state_t'(2);
    localparam state_t S_EXEC_I    = state_t'(3);
    localparam state_t S_ALU_WB    = state_t'(4);
    localparam state_t S_MEM_ADR   = state_t'(5);
    localparam state_t S_MEM_READ  = state_t'(6);
    localparam state_t S_MEM_WB    = state_t'(7);
    localparam state_t S_MEM_WRITE = state_t'(8);
    localparam state_t S_BRANCH    = state_t'(9);
    localparam state_t S_JAL       = state_t'(10);
    localparam state_t S_JALR      = state_t'(11);
    localparam state_t S_JALR_PC   = state_t'(12);
    localparam state_t S_LINK_WB   = state_t'(13);
    localparam state_t S_LUI       = state_t'(14);
    localparam state_t S_ILLEGAL   = state_t'(15);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       f3_ok, r_ok, br_ok, br_take;
    logic [2:0] f3_op;
    logic       pc_en, mem_wr, ir_wr, reg_wr;

    // Supported ALU functions: add/slt/xor/or/and; sub only as R-type with F7=0100000.
    assign f3_ok = (F3 == 3'b000) | (F3 == 3'b010) | (F3 == 3'b100) |
                   (F3 == 3'b110) | (F3 == 3'b111);
    assign r_ok  = f3_ok & ((F7 == 7'h00) | ((F7 == 7'h20) & (F3 == 3'b000)));
    assign br_ok = ~F3[1];

    always_comb begin
        case (F3)
            3'b010:  f3_op = ALU_SUB;
            3'b100:  f3_op = ALU_XOR;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_op = ALU_ADD;
        endcase
    end

    // blt/bge read the raw sign of rs1-rs2, so signed overflow is not corrected.
    always_comb begin
        case (F3)
            3'b000:  br_take = Zero;
            3'b001:  br_take = ~Zero;
            3'b100:  br_take = SignBit;
            3'b101:  br_take = ~SignBit;
            default: br_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_R:          state_d = r_ok  ? S_EXEC_R : S_ILLEGAL;
                    OP_I:          state_d = f3_ok ? S_EXEC_I : S_ILLEGAL;
                    OP_LW, OP_SW:  state_d = S_MEM_ADR;
                    OP_BR:         state_d = br_ok ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:        state_d = S_JAL;
                    OP_JALR:       state_d = S_JALR;
                    OP_LUI:        state_d = S_LUI;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I:  state_d = S_ALU_WB;
            S_MEM_ADR:           state_d = (Op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:          state_d = S_MEM_WB;
            S_JAL, S_JALR_PC:    state_d = S_LINK_WB;
            S_JALR:              state_d = S_JALR_PC;
            S_ILLEGAL:           state_d = S_ILLEGAL;
            S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_LINK_WB, S_LUI:
                                 state_d = S_FETCH;
            default:             state_d = S_ILLEGAL;
        endcase
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_comb begin
        pc_en     = 1'b0;
        mem_wr    = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        AdrSrc    = 1'b0;
        Immsrc    = IMM_I;
        AluSrcA   = 2'b00;
        AluSrcB   = 2'b00;
        AluOp     = ALU_ADD;
        ResultSrc = 2'b00;
        RDS       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_wr     = 1'b1;
                AluSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_en     = 1'b1;
            end
            S_DECODE: begin
                // OldPC+imm lands in AluOutReg as the branch/jal target.
                AluSrcA = 2'b01;
                AluSrcB = 2'b01;
                case (Op)
                    OP_BR:   Immsrc = IMM_B;
                    OP_JAL:  Immsrc = IMM_J;
                    OP_SW:   Immsrc = IMM_S;
                    OP_LUI:  Immsrc = IMM_U;
                    default: Immsrc = IMM_I;
                endcase
            end
            S_EXEC_R: begin
                AluSrcA = 2'b10;
                AluOp   = F7[5] ? ALU_SUB : f3_op;
            end
            S_EXEC_I: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                AluOp   = f3_op;
            end
            S_ALU_WB: begin
                reg_wr    = 1'b1;
                ResultSrc = (F3 == 3'b010) ? 2'b11 : 2'b00;
            end
            S_MEM_ADR: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                Immsrc  = (Op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEM_READ:  AdrSrc = 1'b1;
            S_MEM_WB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
            end
            S_MEM_WRITE: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA = 2'b10;
                AluOp   = ALU_SUB;
                pc_en   = br_take;
            end
            S_JAL, S_JALR_PC: begin
                pc_en   = 1'b1;
                AluSrcA = 2'b01;
                AluSrcB = 2'b10;
            end
            S_JALR: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
            end
            S_LINK_WB: begin
                RDS    = 2'b10;
                reg_wr = 1'b1;
            end
            S_LUI: begin
                Immsrc = IMM_U;
                RDS    = 2'b01;
                reg_wr = 1'b1;
            end
            default: ;
        endcase
    end

    // State sits at FETCH during reset, so architectural enables must be masked.
    assign PcEn     = pc_en  & ~rst;
    assign MemWrite = mem_wr & ~rst;
    assign IrWrite  = ir_wr  & ~rst;
    assign RegWrite = reg_wr & ~rst;
    assign Illegal  = illegal_q;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: behavioural multicycle datapath around the controller; expected fetches and
// writebacks are queued as the program image is built and matched as the DUT emits them.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op, F7;
    logic [2:0] F3;
    logic       Zero, SignBit;
    logic       PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, Illegal;
    logic [2:0] Immsrc, AluOp;
    logic [1:0] AluSrcA, AluSrcB, ResultSrc, RDS;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .F3(F3), .F7(F7), .Zero(Zero), .SignBit(SignBit),
        .PcEn(PcEn), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IrWrite(IrWrite),
        .RegWrite(RegWrite), .Immsrc(Immsrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOp(AluOp), .ResultSrc(ResultSrc), .RDS(RDS), .Illegal(Illegal), .State(State)
    );

    typedef struct { int k; logic [31:0] a; logic [31:0] d; } ev_t;
    ev_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- datapath model ----------------
    logic [31:0] img [256];
    logic [31:0] mem [256];
    logic [31:0] rf  [32];
    logic [31:0] pc, oldpc, ir, aluoutr, mdr, rega, regb, pc_rst;
    logic        sbr;
    logic [31:0] imm, srca, srcb, aluout, res, adr, wd;

    assign Op      = ir[6:0];
    assign F3      = ir[14:12];
    assign F7      = ir[31:25];
    assign Zero    = (aluout == 32'd0);
    assign SignBit = aluout[31];

    always_comb begin
        case (Immsrc)
            3'b000:  imm = {{20{ir[31]}}, ir[31:20]};
            3'b001:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'b010:  imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'b011:  imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {ir[31:12], 12'd0};
        endcase
        case (AluSrcA)
            2'b00:   srca = pc;
            2'b01:   srca = oldpc;
            2'b10:   srca = rega;
            default: srca = 32'd0;
        endcase
        case (AluSrcB)
            2'b00:   srcb = regb;
            2'b01:   srcb = imm;
            2'b10:   srcb = 32'd4;
            default: srcb = 32'd0;
        endcase
        case (AluOp)
            3'b000:  aluout = srca + srcb;
            3'b001:  aluout = srca - srcb;
            3'b010:  aluout = srca & srcb;
            3'b011:  aluout = srca | srcb;
            3'b100:  aluout = srca ^ srcb;
            default: aluout = 32'd0;
        endcase
        case (ResultSrc)
            2'b00:   res = aluoutr;
            2'b01:   res = mdr;
            2'b10:   res = aluout;
            default: res = {31'd0, sbr};
        endcase
        adr = AdrSrc ? res : pc;
        case (RDS)
            2'b00:   wd = res;
            2'b01:   wd = imm;
            default: wd = aluoutr;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            pc  <= pc_rst;
            ir  <= 32'h13;
            mem <= img;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            if (IrWrite) begin
                ir    <= mem[adr[9:2]];
                oldpc <= pc;
            end
            if (PcEn) pc <= res;
            aluoutr <= aluout;
            sbr     <= aluout[31];
            mdr     <= mem[adr[9:2]];
            rega    <= rf[ir[19:15]];
            regb    <= rf[ir[24:20]];
            if (MemWrite) mem[adr[9:2]] <= regb;
            if (RegWrite && ir[11:7] != 5'd0) rf[ir[11:7]] <= wd;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic run = 1'b0;
    int   cnt = 0, last = 0, have = 0;

    task automatic ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t   e;
        string t;
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.k == 2)      t = "fetch_pc_cycles";
            else if (e.k == 1) t = "memwr_adr_data";
            else               t = "regwr_rd_data";
            chk("ev_kind", 64'(k), 64'(e.k));
            chk(t, {a, d}, {e.a, e.d});
        end
    endtask

    always @(negedge clk) begin
        if (!rst && run) begin
            cnt++;
            if (IrWrite) begin
                ev(2, pc, (have != 0) ? 32'(cnt - last) : 32'd0);
                have = 1;
                last = cnt;
            end
            if (RegWrite) ev(0, {27'd0, ir[11:7]}, wd);
            if (MemWrite) ev(1, adr, regb);
        end
    end

    // ---------------- encoders / program builder ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input int im, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {im[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int im, input int rs2, input int rs1);
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                          input int im);
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input int im);
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input int rd, input int im20);
        return {im20[19:0], rd[4:0], 7'b0110111};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam int         NOW = 2;  // no writeback event

    int prev_cyc = 0;

    // Place one instruction and queue its fetch (with the previous instruction's length)
    // and its writeback, if any.
    task automatic put(input logic [31:0] at, input logic [31:0] ins, input int cyc,
                       input int k, input logic [31:0] a, input logic [31:0] d);
        img[at[9:2]] = ins;
        sb.push_back('{k: 2, a: at, d: 32'(prev_cyc)});
        prev_cyc = cyc;
        if (k < 2) sb.push_back('{k: k, a: a, d: d});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [3:0] quiet;
        rst    = 1'b1;
        pc_rst = 32'h80;
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
        img[32'h80 >> 2] = enc_s(8, 1, 0);  // sw x1,8(x0)
        repeat (2) @(negedge clk);
        chk("rst_state",   64'(State), 64'd0);
        chk("rst_illegal", 64'(Illegal), 64'd0);
        chk("rst_enables", 64'({PcEn, MemWrite, IrWrite, RegWrite}), 64'd0);

        // Reset in the middle of a store must kill MemWrite immediately.
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        while (State != 4'd8 && n < 20) begin @(negedge clk); n++; end
        chk("memw_reached", 64'(State), 64'd8);
        chk("memw_active",  64'(MemWrite), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_memwrite", 64'(MemWrite), 64'd0);
        chk("abort_state",    64'(State), 64'd0);
        chk("abort_illegal",  64'(Illegal), 64'd0);

        // Main program.
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
        img[2] = 32'hDEADBEEF;
        put(32'h80, enc_i(OPI,  5, 0, 3'b000, 1), 4, 0, 1, 32'd5);
        put(32'h84, enc_i(OPI,  7, 0, 3'b000, 2), 4, 0, 2, 32'd7);
        put(32'h88, enc_r(7'h00, 2, 1, 3'b000, 3), 4, 0, 3, 32'd12);
        put(32'h8C, enc_i(OPI, -1, 0, 3'b000, 1), 4, 0, 1, 32'hFFFFFFFF);
        put(32'h90, enc_i(OPI,  3, 0, 3'b000, 2), 4, 0, 2, 32'd3);
        put(32'h94, enc_r(7'h00, 2, 1, 3'b010, 4), 4, 0, 4, 32'd1);
        put(32'h98, enc_r(7'h00, 1, 2, 3'b010, 4), 4, 0, 4, 32'd0);
        put(32'h9C, enc_i(OPL,  8, 0, 3'b010, 5), 5, 0, 5, 32'hDEADBEEF);
        put(32'hA0, enc_s(8, 3, 0),                4, 1, 32'd8, 32'd12);
        put(32'hA4, enc_i(OPL,  8, 0, 3'b010, 6), 5, 0, 6, 32'd12);
        put(32'hA8, enc_r(7'h20, 1, 3, 3'b000, 7), 4, 0, 7, 32'd13);
        put(32'hAC, enc_r(7'h00, 2, 3, 3'b111, 8), 4, 0, 8, 32'd0);
        put(32'hB0, enc_r(7'h00, 2, 3, 3'b110, 9), 4, 0, 9, 32'd15);
        put(32'hB4, enc_r(7'h00, 1, 3, 3'b100, 10), 4, 0, 10, 32'hFFFFFFF3);
        put(32'hB8, enc_i(OPI, 10, 3, 3'b111, 11), 4, 0, 11, 32'd8);
        put(32'hBC, enc_i(OPI,  1, 3, 3'b110, 12), 4, 0, 12, 32'd13);
        put(32'hC0, enc_i(OPI, -1, 3, 3'b100, 13), 4, 0, 13, 32'hFFFFFFF3);
        put(32'hC4, enc_i(OPI,  0, 1, 3'b010, 14), 4, 0, 14, 32'd1);
        put(32'hC8, enc_i(OPI, 32'h100, 0, 3'b000, 2), 4, 0, 2, 32'h100);
        put(32'hCC, enc_u(15, 32'h12345),          3, 0, 15, 32'h12345000);
        put(32'hD0, enc_j(0, -192),                4, 0, 0, 32'hD4);
        put(32'h10, enc_b(3'b000, 1, 1, 16),       3, NOW, 0, 0);  // beq taken
        put(32'h20, enc_b(3'b001, 1, 1, 16),       3, NOW, 0, 0);  // bne not taken
        put(32'h24, enc_b(3'b100, 1, 3, 16),       3, NOW, 0, 0);  // blt taken
        put(32'h34, enc_b(3'b101, 1, 3, 16),       3, NOW, 0, 0);  // bge not taken
        put(32'h38, enc_b(3'b101, 3, 1, 8),        3, NOW, 0, 0);  // bge taken
        put(32'h40, enc_j(1, 32),                  4, 0, 1, 32'h44);
        put(32'h60, enc_i(7'b1100111, 4, 2, 3'b000, 1), 5, 0, 1, 32'h64);
        put(32'h104, enc_b(3'b000, 1, 2, 8),       3, NOW, 0, 0);  // beq not taken
        put(32'h108, enc_b(3'b001, 1, 2, 8),       3, NOW, 0, 0);  // bne taken
        put(32'h110, 32'h0000007F,                 0, NOW, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_irwrite", 64'(IrWrite), 64'd0);
        chk("rst_hold_pcen",    64'(PcEn), 64'd0);

        @(posedge clk); #1;
        run = 1'b1;
        rst = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        repeat (3) @(negedge clk);
        chk("illegal_set",   64'(Illegal), 64'd1);
        chk("illegal_state", 64'(State), 64'd15);
        quiet = 4'd0;
        repeat (10) begin
            @(negedge clk);
            quiet = quiet | {PcEn, MemWrite, IrWrite, RegWrite};
        end
        chk("illegal_no_writes", 64'(quiet), 64'd0);
        chk("illegal_sticky",    64'(Illegal), 64'd1);

        rst = 1'b1;
        #1;
        chk("rst_clears_illegal", 64'(Illegal), 64'd0);
        chk("rst_from_illegal",   64'(State), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
